// File: rtl/dual_issue_perf_monitor_pkg.sv
// Shared definitions for the dual-issue performance monitor: read-port
// addresses, the RISC-V control-flow opcodes it counts, and the NOP encoding.
package perf_pkg;

    localparam int NUM_CNT = 6;

    typedef enum logic [2:0] {
        A_CYC     = 3'd0,
        A_INSTR   = 3'd1,
        A_BR      = 3'd2,
        A_BRMISS  = 3'd3,
        A_JMP     = 3'd4,
        A_JMPMISS = 3'd5,
        A_STATUS  = 3'd6,
        A_RSVD    = 3'd7
    } cnt_addr_e;

    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [31:0] NOP_ENC   = 32'h00000013;

    function automatic logic [1:0] count2(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/dual_issue_perf_monitor_sat_counter.sv
// Saturating event counter taking 0..2 events per cycle; ovf flags that the
// requested increment did not fit and the count was pinned at all-ones.
module perf_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] q,
    output logic             ovf
);

    logic [CNT_W:0] sum;

    assign sum = {1'b0, q} + {{(CNT_W-1){1'b0}}, inc};
    assign ovf = sum[CNT_W];

    always_ff @(posedge clk) begin
        if (!reset || clear)
            q <= '0;
        else
            q <= ovf ? '1 : sum[CNT_W-1:0];
    end

endmodule

// File: rtl/dual_issue_perf_monitor.sv
// Passive performance monitor for the dual-issue pipeline: per-slot event
// counting, program-completion / timeout detection and a 1-cycle read port.
module dual_issue_perf_monitor
    import perf_pkg::*;
#(
    parameter int          CNT_W      = 32,
    parameter logic [31:0] NOP        = NOP_ENC,
    parameter int          MAX_CYCLES = 500
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clear_i,
    input  logic [31:0]      instrD_i,
    input  logic [31:0]      instrD2_i,
    input  logic [6:0]       opE_i,
    input  logic [6:0]       opE2_i,
    input  logic             mispredictE_i,
    input  logic             mispredictE2_i,
    input  logic             predTakenF_i,
    input  logic             predTakenF2_i,
    input  logic [31:0]      pcF_i,
    input  logic [31:0]      pcF2_i,
    input  logic [31:0]      instrF_i,
    input  logic [31:0]      instrF2_i,
    input  logic             rd_req_i,
    input  logic [2:0]       rd_addr_i,
    output logic             rd_ack_o,
    output logic [CNT_W-1:0] rd_data_o,
    output logic             halted_o,
    output logic             timeout_o
);

    localparam logic [63:0] MAX_L = 64'(MAX_CYCLES);

    logic                            halted_q, timeout_q, sat_any_q;
    logic [31:0]                     prev_pc1, prev_pc2;
    logic                            halt_det, count_en, to_hit;
    logic                            vld1, vld2, br1, br2, jmp1, jmp2;
    logic [NUM_CNT-1:0][1:0]         inc;
    logic [NUM_CNT-1:0][CNT_W-1:0]   cnt;
    logic [NUM_CNT-1:0]              ovf;
    logic [63:0]                     cyc_nxt;
    logic [CNT_W-1:0]                rd_mux;

    // Both fetch slots parked on a NOP at the PC they held last cycle.
    assign halt_det = en_i && (pcF_i == prev_pc1) && (instrF_i == NOP)
                           && (pcF2_i == prev_pc2) && (instrF2_i == NOP);
    assign count_en = en_i && !halted_q && !timeout_q && !halt_det;

    assign vld1 = (instrD_i  != '0) && (instrD_i  != NOP);
    assign vld2 = (instrD2_i != '0) && (instrD2_i != NOP);
    assign br1  = (opE_i  == OP_BRANCH);
    assign br2  = (opE2_i == OP_BRANCH);
    assign jmp1 = (opE_i  == OP_JAL) || (opE_i  == OP_JALR);
    assign jmp2 = (opE2_i == OP_JAL) || (opE2_i == OP_JALR);

    always_comb begin
        inc = '0;
        if (count_en) begin
            inc[A_CYC]     = 2'd1;
            inc[A_INSTR]   = count2(vld1, vld2);
            inc[A_BR]      = count2(br1, br2);
            inc[A_BRMISS]  = count2(br1 && mispredictE_i, br2 && mispredictE2_i);
            inc[A_JMP]     = count2(jmp1, jmp2);
            inc[A_JMPMISS] = count2(jmp1 && !predTakenF_i, jmp2 && !predTakenF2_i);
        end
    end

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        perf_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clear (clear_i),
            .inc   (inc[i]),
            .q     (cnt[i]),
            .ovf   (ovf[i])
        );
    end

    // Timeout fires on the edge that brings CYC to MAX_CYCLES, so CYC parks there.
    assign cyc_nxt = 64'(cnt[A_CYC]) + (ovf[A_CYC] ? 64'd0 : 64'd1);
    assign to_hit  = count_en && (cyc_nxt >= MAX_L);

    always_ff @(posedge clk) begin
        if (!reset || clear_i) begin
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
            sat_any_q <= 1'b0;
            prev_pc1  <= '0;
            prev_pc2  <= '0;
        end else begin
            if (halt_det)  halted_q  <= 1'b1;
            if (to_hit)    timeout_q <= 1'b1;
            if (|ovf)      sat_any_q <= 1'b1;
            if (en_i) begin
                prev_pc1 <= pcF_i;
                prev_pc2 <= pcF2_i;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (cnt_addr_e'(rd_addr_i))
            A_CYC:     rd_mux = cnt[A_CYC];
            A_INSTR:   rd_mux = cnt[A_INSTR];
            A_BR:      rd_mux = cnt[A_BR];
            A_BRMISS:  rd_mux = cnt[A_BRMISS];
            A_JMP:     rd_mux = cnt[A_JMP];
            A_JMPMISS: rd_mux = cnt[A_JMPMISS];
            A_STATUS:  rd_mux = {{(CNT_W-3){1'b0}}, sat_any_q, timeout_q, halted_q};
            default:   rd_mux = '0;
        endcase
    end

    // Read port ignores clear_i: a read in the clear cycle returns pre-clear data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ack_o  <= 1'b0;
            rd_data_o <= '0;
        end else begin
            rd_ack_o <= rd_req_i;
            if (rd_req_i)
                rd_data_o <= rd_mux;
        end
    end

    assign halted_o  = halted_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_dual_issue_perf_monitor.sv
// Bench for dual_issue_perf_monitor: a wide default instance and a narrow
// (4-bit, MAX_CYCLES=8) instance share stimulus and are checked each cycle.
module tb_dual_issue_perf_monitor;

    localparam logic [31:0] NOPI = 32'h00000013;
    localparam logic [6:0]  BR   = 7'b1100011;
    localparam logic [6:0]  JAL  = 7'b1101111;
    localparam logic [6:0]  JALR = 7'b1100111;

    logic        clk = 0, reset = 0, en_i = 0, clear_i = 0;
    logic [31:0] instrD_i = 0, instrD2_i = 0, pcF_i = 0, pcF2_i = 4;
    logic [31:0] instrF_i = 1, instrF2_i = 1;
    logic [6:0]  opE_i = 0, opE2_i = 0;
    logic        mispredictE_i = 0, mispredictE2_i = 0, predTakenF_i = 0, predTakenF2_i = 0;
    logic        rd_req_i = 0;
    logic [2:0]  rd_addr_i = 0;

    logic        ack_b, ack_s, halt_b, halt_s, to_b, to_s;
    logic [31:0] data_b;
    logic [3:0]  data_s;

    int checks = 0, errors = 0;
    bit started = 0, hold_pc = 0;

    always #5 clk = ~clk;

    dual_issue_perf_monitor u_big (
        .clk(clk), .reset(reset), .en_i(en_i), .clear_i(clear_i),
        .instrD_i(instrD_i), .instrD2_i(instrD2_i), .opE_i(opE_i), .opE2_i(opE2_i),
        .mispredictE_i(mispredictE_i), .mispredictE2_i(mispredictE2_i),
        .predTakenF_i(predTakenF_i), .predTakenF2_i(predTakenF2_i),
        .pcF_i(pcF_i), .pcF2_i(pcF2_i), .instrF_i(instrF_i), .instrF2_i(instrF2_i),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_ack_o(ack_b), .rd_data_o(data_b),
        .halted_o(halt_b), .timeout_o(to_b));

    dual_issue_perf_monitor #(.CNT_W(4), .MAX_CYCLES(8)) u_small (
        .clk(clk), .reset(reset), .en_i(en_i), .clear_i(clear_i),
        .instrD_i(instrD_i), .instrD2_i(instrD2_i), .opE_i(opE_i), .opE2_i(opE2_i),
        .mispredictE_i(mispredictE_i), .mispredictE2_i(mispredictE2_i),
        .predTakenF_i(predTakenF_i), .predTakenF2_i(predTakenF2_i),
        .pcF_i(pcF_i), .pcF2_i(pcF2_i), .instrF_i(instrF_i), .instrF2_i(instrF2_i),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_ack_o(ack_s), .rd_data_o(data_s),
        .halted_o(halt_s), .timeout_o(to_s));

    // ---------------- behavioural model (index 0 = wide, 1 = narrow) ----------------
    longint      mc [2][6];
    bit          mh [2], mt [2], ms [2], mack [2];
    longint      mdata [2];
    longint      maxv [2] = '{64'hFFFFFFFF, 64'd15};
    longint      mmax [2] = '{64'd500, 64'd8};
    logic [31:0] mp1 = 0, mp2 = 0;

    function automatic int valid_i(input logic [31:0] i);
        return (i != 0 && i != NOPI) ? 1 : 0;
    endfunction

    function automatic int is_jmp(input logic [6:0] op);
        return (op == JAL || op == JALR) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        int inc [6];
        bit halt;
        halt   = en_i && pcF_i == mp1 && instrF_i == NOPI && pcF2_i == mp2 && instrF2_i == NOPI;
        inc[0] = 1;
        inc[1] = valid_i(instrD_i) + valid_i(instrD2_i);
        inc[2] = int'(opE_i == BR) + int'(opE2_i == BR);
        inc[3] = int'(opE_i == BR && mispredictE_i) + int'(opE2_i == BR && mispredictE2_i);
        inc[4] = is_jmp(opE_i) + is_jmp(opE2_i);
        inc[5] = (is_jmp(opE_i) & int'(!predTakenF_i)) + (is_jmp(opE2_i) & int'(!predTakenF2_i));
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                for (int c = 0; c < 6; c++) mc[k][c] = 0;
                mh[k] = 0; mt[k] = 0; ms[k] = 0; mack[k] = 0; mdata[k] = 0;
            end else begin
                mack[k] = rd_req_i;
                if (rd_req_i)
                    mdata[k] = (rd_addr_i < 6) ? mc[k][rd_addr_i] :
                               (rd_addr_i == 6) ? longint'(ms[k]) * 4 + longint'(mt[k]) * 2 + longint'(mh[k]) : 0;
                if (clear_i) begin
                    for (int c = 0; c < 6; c++) mc[k][c] = 0;
                    mh[k] = 0; mt[k] = 0; ms[k] = 0;
                end else begin
                    if (en_i && !mh[k] && !mt[k] && !halt) begin
                        for (int c = 0; c < 6; c++) begin
                            if (mc[k][c] + inc[c] > maxv[k]) begin
                                ms[k] = 1;
                                mc[k][c] = maxv[k];
                            end else
                                mc[k][c] = mc[k][c] + inc[c];
                        end
                        if (mc[k][0] >= mmax[k]) mt[k] = 1;
                    end
                    if (halt) mh[k] = 1;
                end
            end
        end
        if (!reset || clear_i) begin
            mp1 = 0; mp2 = 0;
        end else if (en_i) begin
            mp1 = pcF_i; mp2 = pcF2_i;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("ack_big",   64'(ack_b),  64'(mack[0]));
            chk("data_big",  64'(data_b), mdata[0]);
            chk("halt_big",  64'(halt_b), 64'(mh[0]));
            chk("to_big",    64'(to_b),   64'(mt[0]));
            chk("ack_small", 64'(ack_s),  64'(mack[1]));
            chk("data_small",64'(data_s), mdata[1]);
            chk("halt_small",64'(halt_s), 64'(mh[1]));
            chk("to_small",  64'(to_s),   64'(mt[1]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            if (!hold_pc) begin
                pcF_i  = pcF_i + 8;
                pcF2_i = pcF2_i + 8;
            end
        end
    endtask

    // One-cycle read; checks wide/narrow result and pins the model on the same value.
    task automatic rd(input logic [2:0] a, input logic [63:0] eb, input logic [63:0] es);
        rd_req_i  = 1;
        rd_addr_i = a;
        tick(1);
        rd_req_i = 0;
        @(negedge clk);
        chk($sformatf("rd%0d_big", a),   64'(data_b), eb);
        chk($sformatf("rd%0d_small", a), 64'(data_s), es);
        chk($sformatf("rd%0d_ack", a),   64'(ack_b),  64'd1);
        chk($sformatf("rd%0d_model", a), mdata[0],    eb);
    endtask

    initial begin
        // reset held two cycles
        tick(2);
        started = 1;
        @(negedge clk);
        chk("rst_ack",  64'(ack_b),  0);
        chk("rst_data", 64'(data_b), 0);
        chk("rst_halt", 64'(halt_b), 0);
        chk("rst_to",   64'(to_b),   0);

        // ten cycles of NOP decode
        reset = 1; en_i = 1; instrD_i = NOPI; instrD2_i = NOPI;
        tick(10);
        rd(3'd0, 10, 8);
        chk("small_timeout", 64'(to_s), 1);
        rd(3'd1, 0, 0);
        rd(3'd6, 0, 2);

        // 5 cycles dual decode, 3 cycles slot1 only
        instrD_i = 32'h00a00093; instrD2_i = 32'h00b00113;
        tick(5);
        instrD2_i = NOPI;
        tick(3);
        instrD_i = NOPI;
        rd(3'd1, 13, 0);

        // dual branch with slot1 mispredict, then slot2 JALR not predicted
        opE_i = BR; opE2_i = BR; mispredictE_i = 1; mispredictE2_i = 0;
        tick(1);
        opE_i = 0; mispredictE_i = 0; opE2_i = JALR; predTakenF2_i = 0;
        tick(1);
        opE2_i = 0;
        rd(3'd2, 2, 0);
        rd(3'd3, 1, 0);
        rd(3'd4, 1, 0);
        rd(3'd5, 1, 0);

        // both fetch slots parked on NOP at 0x40/0x44
        hold_pc = 1; pcF_i = 32'h40; pcF2_i = 32'h44; instrF_i = NOPI; instrF2_i = NOPI;
        tick(2);
        @(negedge clk);
        chk("halt_set", 64'(halt_b), 1);
        rd(3'd0, 29, 8);
        tick(3);
        rd(3'd0, 29, 8);
        rd(3'd6, 1, 3);

        // clear, count 7, then clear together with a CYC read
        hold_pc = 0; instrF_i = 1; instrF2_i = 1;
        clear_i = 1; tick(1); clear_i = 0;
        tick(7);
        clear_i = 1;
        rd(3'd0, 7, 7);
        clear_i = 0;
        rd(3'd0, 0, 0);

        // saturation of the narrow INSTR counter
        clear_i = 1; tick(1); clear_i = 0;
        instrD_i = 32'h00a00093; instrD2_i = 32'h00b00113;
        tick(10);
        instrD_i = NOPI; instrD2_i = NOPI;
        rd(3'd1, 20, 15);
        rd(3'd6, 0, 6);
        rd(3'd7, 0, 0);

        // randomized traffic
        hold_pc = 1;
        for (int i = 0; i < 600; i++) begin
            int r;
            en_i      = ($urandom % 8) != 0;
            clear_i   = ($urandom % 50) == 0;
            reset     = ($urandom % 150) != 0;
            r = $urandom % 4;
            instrD_i  = (r == 0) ? 32'd0 : (r == 1) ? NOPI : $urandom;
            r = $urandom % 4;
            instrD2_i = (r == 0) ? 32'd0 : (r == 1) ? NOPI : $urandom;
            r = $urandom % 4;
            opE_i  = (r == 0) ? BR : (r == 1) ? JAL : (r == 2) ? JALR : 7'($urandom);
            r = $urandom % 4;
            opE2_i = (r == 0) ? BR : (r == 1) ? JAL : (r == 2) ? JALR : 7'($urandom);
            mispredictE_i  = 1'($urandom); mispredictE2_i = 1'($urandom);
            predTakenF_i   = 1'($urandom); predTakenF2_i  = 1'($urandom);
            pcF_i     = ($urandom % 3 == 0) ? 32'h40 : $urandom;
            pcF2_i    = ($urandom % 3 == 0) ? 32'h44 : $urandom;
            instrF_i  = ($urandom % 2 == 0) ? NOPI : $urandom;
            instrF2_i = ($urandom % 2 == 0) ? NOPI : $urandom;
            rd_req_i  = 1'($urandom);
            rd_addr_i = 3'($urandom);
            tick(1);
        end

        // reset pulsed mid-run
        reset = 1; clear_i = 0; en_i = 1; rd_req_i = 1; rd_addr_i = 0;
        tick(3);
        reset = 0;
        tick(1);
        @(negedge clk);
        chk("mid_rst_ack",  64'(ack_b),  0);
        chk("mid_rst_data", 64'(data_b), 0);
        chk("mid_rst_halt", 64'(halt_b), 0);
        chk("mid_rst_to",   64'(to_s),   0);
        reset = 1; rd_req_i = 0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
